decoder_scan_seq: RTL



---
 rtl/decoder_scan_seq_pkg.sv | 19 +
 rtl/decoder_scan_seq_next_row.sv | 39 +++
 rtl/decoder_scan_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_scan_pkg
//   Shared types and constants for the 3-to-8 decoder scan sequencer.
//   scan_state_t : sequencer states (IDLE, BLANK, DRIVE)
//   SCAN_ROWS    : number of decoder outputs scanned
//   SCAN_SEL_W   : width of the decoder select bus
// -----------------------------------------------------------------------------
package decoder_scan_pkg;

    localparam int SCAN_ROWS  = 8;
    localparam int SCAN_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/decoder_scan_seq_next_row.sv
// -----------------------------------------------------------------------------
// scan_next_row
//   Combinational rotate-priority search: finds the first set bit of row_mask
//   strictly above cur, wrapping from the top row back to row 0. A lone set
//   bit at cur itself is found after a full turn.
//   Ports:
//     cur      in  SCAN_SEL_W : row the search starts after
//     row_mask in  SCAN_ROWS  : bit i=1 means row i is eligible
//     next     out SCAN_SEL_W : index of the row found (cur if none)
//     valid    out 1          : a row was found (row_mask != 0)
//     wrap     out 1          : the search passed the top row (next <= cur)
// -----------------------------------------------------------------------------
module scan_next_row
    import decoder_scan_pkg::*;
(
    input  logic [SCAN_SEL_W-1:0] cur,
    input  logic [SCAN_ROWS-1:0]  row_mask,
    output logic [SCAN_SEL_W-1:0] next,
    output logic                  valid,
    output logic                  wrap
);

    always_comb begin
        // NOTE: every output gets a default before the search loop so that no
        // path leaves a value unassigned, which would otherwise infer a latch.
        next  = cur;
        valid = 1'b0;
        wrap  = 1'b0;
        // Offsets 1..SCAN_ROWS; offset SCAN_ROWS lands back on cur itself.
        for (int k = 1; k <= SCAN_ROWS; k++) begin
            if (!valid && row_mask[SCAN_SEL_W'(int'(cur) + k)]) begin
                valid = 1'b1;
                next  = SCAN_SEL_W'(int'(cur) + k);
                wrap  = (int'(cur) + k) >= SCAN_ROWS;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_seq.sv
// -----------------------------------------------------------------------------
// decoder_scan_seq
//   Scan sequencer driving the select (A) and enable (E) of a 3-to-8 decoder.
//   Steps through the rows enabled in row_mask in ascending order, holding
//   each one active for dwell+1 cycles, with E low for BLANK_CYCLES cycles on
//   every row change so the decoder never glitches between rows.
//
//   Build option: DECODER_SCAN_BLANK_EN
//     defined   : blanking gap present (IDLE -> BLANK -> DRIVE -> BLANK ...)
//     undefined : no BLANK state; rows change back-to-back with E held high,
//                 stop is honoured only at the end of a row, and BLANK_CYCLES
//                 has no effect.
//
//   Parameters:
//     DWELL_W      : width of the dwell input
//     BLANK_CYCLES : E-low cycles before each row is driven (>= 1)
//   Ports:
//     clk        in  1       : clock, rising edge
//     rst_n      in  1       : asynchronous active-low reset
//     start      in  1       : begin scanning (looked at only in IDLE)
//     stop       in  1       : end scanning (BLANK: at once, DRIVE: end of row)
//     dwell      in  DWELL_W : drive cycles per row minus 1, taken on DRIVE entry
//     row_mask   in  8       : rows to scan, read live at each row selection
//     A          out 3       : decoder select, registered
//     E          out 1       : decoder enable, registered
//     busy       out 1       : high whenever not IDLE
//     frame_done out 1       : one-cycle pulse when a pass over the rows ends
// -----------------------------------------------------------------------------
module decoder_scan_seq
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic [SCAN_ROWS-1:0]  row_mask,
    output logic [SCAN_SEL_W-1:0] A,
    output logic                  E,
    output logic                  busy,
    output logic                  frame_done
);

    scan_state_t           state, state_nxt;
    logic [SCAN_SEL_W-1:0] a_nxt;
    logic                  e_nxt;
    logic                  fd_nxt;
    logic [DWELL_W-1:0]    dwell_cnt, dwell_nxt;
    logic                  stop_pend, stop_nxt;

`ifdef DECODER_SCAN_BLANK_EN
    localparam int                  BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0]  BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    logic [BLANK_W-1:0]             blank_cnt, blank_nxt;
`else
    logic unused_blank_cycles;
    assign unused_blank_cycles = |BLANK_CYCLES;
`endif

    // From IDLE the search starts after the top row, which yields the lowest
    // enabled row; otherwise it starts after the row currently selected.
    logic [SCAN_SEL_W-1:0] srch_cur;
    logic [SCAN_SEL_W-1:0] srch_next;
    logic                  srch_valid;
    logic                  srch_wrap;

    assign srch_cur = (state == IDLE) ? SCAN_SEL_W'(SCAN_ROWS - 1) : A;

    scan_next_row u_next_row (
        .cur      (srch_cur),
        .row_mask (row_mask),
        .next     (srch_next),
        .valid    (srch_valid),
        .wrap     (srch_wrap)
    );

    assign busy = (state != IDLE);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        a_nxt     = A;
        e_nxt     = E;
        fd_nxt    = 1'b0;
        dwell_nxt = dwell_cnt;
        stop_nxt  = stop_pend;
`ifdef DECODER_SCAN_BLANK_EN
        blank_nxt = blank_cnt;
`endif

        case (state)
            IDLE: begin
                e_nxt    = 1'b0;
                stop_nxt = 1'b0;
                if (start && !stop && srch_valid) begin
                    a_nxt = srch_next;
`ifdef DECODER_SCAN_BLANK_EN
                    state_nxt = BLANK;
                    blank_nxt = '0;
`else
                    state_nxt = DRIVE;
                    e_nxt     = 1'b1;
                    dwell_nxt = dwell;
`endif
                end
            end

`ifdef DECODER_SCAN_BLANK_EN
            BLANK: begin
                e_nxt = 1'b0;
                if (stop) begin
                    state_nxt = IDLE;
                    blank_nxt = '0;
                end else if (blank_cnt == BLANK_LAST) begin
                    state_nxt = DRIVE;
                    e_nxt     = 1'b1;
                    dwell_nxt = dwell;
                    blank_nxt = '0;
                end else begin
                    blank_nxt = blank_cnt + 1'b1;
                end
            end
`endif

            DRIVE: begin
                // A stop anywhere in the row is remembered; the row completes.
                stop_nxt = stop_pend | stop;
                if (dwell_cnt != '0) begin
                    dwell_nxt = dwell_cnt - 1'b1;
                end else if (!srch_valid) begin
                    // Mask emptied: end quietly, no frame_done.
                    state_nxt = IDLE;
                    e_nxt     = 1'b0;
                    stop_nxt  = 1'b0;
                end else begin
                    fd_nxt = srch_wrap;
                    if (stop_pend || stop) begin
                        state_nxt = IDLE;
                        e_nxt     = 1'b0;
                        stop_nxt  = 1'b0;
                    end else begin
                        a_nxt = srch_next;
`ifdef DECODER_SCAN_BLANK_EN
                        state_nxt = BLANK;
                        e_nxt     = 1'b0;
`else
                        dwell_nxt = dwell;
`endif
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                e_nxt     = 1'b0;
                stop_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            A          <= '0;
            E          <= 1'b0;
            frame_done <= 1'b0;
            dwell_cnt  <= '0;
            stop_pend  <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            blank_cnt  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            state      <= state_nxt;
            A          <= a_nxt;
            E          <= e_nxt;
            frame_done <= fd_nxt;
            dwell_cnt  <= dwell_nxt;
            stop_pend  <= stop_nxt;
`ifdef DECODER_SCAN_BLANK_EN
            blank_cnt  <= blank_nxt;
`endif
        end
    end

endmodule
